// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0), shown to decode when no entry is valid
//   RESET_VECTOR  : default PC after reset
//   fetch_entry_t : one fetch buffer entry {pc, instr}
package riscv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO at the next edge; overrides push and pop
//   push, din  : write request and entry
//   pop        : consume the head entry
//   head       : entry at the head (meaningless while empty)
//   count      : number of stored entries
//   full/empty : status flags
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  fetch_entry_t                   din,
    input  logic                           pop,
    output fetch_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch stage in front of a combinational instruction memory.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_pc         : fetch address (the PC register)
//   imem_instr      : instruction returned combinationally for imem_pc
//   redirect_valid  : branch/jump redirect from execute, flushes in-flight fetches
//   redirect_pc     : redirect target (low two bits ignored)
//   out_valid/ready : handshake towards decode
//   out_instr       : instruction at the buffer head, NOP when empty
//   out_pc          : PC of out_instr, 0 when empty
//   out_pc_plus4    : out_pc + 4
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic             push, pop;
    fetch_entry_t     push_entry, head;
    logic [CNT_W-1:0] count;
    logic             full, empty;

    assign imem_pc = pc_q;

    assign pop  = out_valid & out_ready;
    // Redirect suppresses the push; a full buffer accepts only when its head drains.
    assign push = ~redirect_valid & (~full | pop);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_instr;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid    = (count != '0);
    assign out_instr    = empty ? NOP_INSTR : head.instr;
    assign out_pc       = empty ? 32'd0     : head.pc;
    assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    // Combinational instruction memory model.
    function automatic logic [31:0] imem_model(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0010_0093;
            32'h0000_0004: return 32'h0020_0113;
            32'h0000_0008: return 32'h0020_81b3;
            32'h0000_0010: return 32'h0050_0293;
            32'h0000_0014: return 32'h0060_0313;
            32'h0000_001C: return 32'h0000_2203;
            32'h0000_0020: return 32'h0040_2023;
            32'hFFFF_FFFC: return 32'h0070_0393;
            default:       return 32'h0000_0033;
        endcase
    endfunction

    always_comb imem_instr = imem_model(imem_pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge, away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, out_instr, instr);
        check({tag, ".pc4"}, out_pc_plus4, pc + 32'd4);
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) step();

        // Reset state
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.instr", out_instr, 32'h0000_0013);
        check("rst.pc", out_pc, 32'd0);
        check("rst.pc4", out_pc_plus4, 32'd4);
        check("rst.imem_pc", imem_pc, 32'd0);

        // 1: streaming with out_ready high
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step(); check_out("t1.a", 32'h0, 32'h0010_0093);
        step(); check_out("t1.b", 32'h4, 32'h0020_0113);
        step(); check_out("t1.c", 32'h8, 32'h0020_81b3);

        // 2: back-pressure fills the buffer, then drains in order
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        step(); check_out("t2.e1", 32'h0, 32'h0010_0093);
        step(); check("t2.e2.imem_pc", imem_pc, 32'h8);
        step(); check("t2.e3.imem_pc", imem_pc, 32'h8);
        check_out("t2.e3", 32'h0, 32'h0010_0093);
        step(); check("t2.e4.imem_pc", imem_pc, 32'h8);
        check_out("t2.e4", 32'h0, 32'h0010_0093);
        out_ready = 1'b1;
        step(); check_out("t2.d1", 32'h4, 32'h0020_0113);
        step(); check_out("t2.d2", 32'h8, 32'h0020_81b3);

        // 3: redirect while full
        out_ready = 1'b0;
        step(); check("t3.full.imem_pc", imem_pc, 32'h10);
        check_out("t3.full", 32'h8, 32'h0020_81b3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        step();
        check("t3.flush.valid", {31'd0, out_valid}, 32'd0);
        check("t3.flush.imem_pc", imem_pc, 32'h1C);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step(); check_out("t3.a", 32'h1C, 32'h0000_2203);
        step(); check_out("t3.b", 32'h20, 32'h0040_2023);

        // 4: misaligned target, then back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1E;
        step();
        check("t4.mis.valid", {31'd0, out_valid}, 32'd0);
        check("t4.mis.imem_pc", imem_pc, 32'h1C);
        redirect_valid = 1'b0;
        step(); check_out("t4.mis", 32'h1C, 32'h0000_2203);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step(); check("t4.r1.valid", {31'd0, out_valid}, 32'd0);
        redirect_pc = 32'h14;
        step(); check("t4.r2.valid", {31'd0, out_valid}, 32'd0);
        check("t4.r2.imem_pc", imem_pc, 32'h14);
        redirect_valid = 1'b0;
        step(); check_out("t4.b2b", 32'h14, 32'h0060_0313);

        // 5: asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("t5.valid", {31'd0, out_valid}, 32'd0);
        check("t5.imem_pc", imem_pc, 32'h0);
        check("t5.instr", out_instr, 32'h0000_0013);
        #1;
        rst_n = 1'b1;
        step(); check_out("t5.a", 32'h0, 32'h0010_0093);
        step(); check_out("t5.b", 32'h4, 32'h0020_0113);

        // 6: PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(); check("t6.flush.valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        step(); check_out("t6.a", 32'hFFFF_FFFC, 32'h0070_0393);
        check("t6.a.pc4wrap", out_pc_plus4, 32'h0);
        step(); check_out("t6.b", 32'h0, 32'h0010_0093);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
